data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder.sv | 117 +++++++++++
 tb/tb_data_memory_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: single-outstanding word memory with fixed
// access latency, byte-lane stores and misalign/range error reporting.
module data_memory_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic        r_wr;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;
   logic [31:0] r_mem [DEPTH];

   logic                  w_accept;
   logic                  w_fire;
   logic                  w_done;
   logic                  w_err;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [1:0]            w_state_nx;

   assign w_accept = req_valid && r_req_ready;
   assign w_fire   = (r_state == S_WAIT) && (r_cnt == 4'd1);
   assign w_done   = (r_state == S_RESP) && rsp_ready;
   assign w_idx    = r_addr[ADDR_WIDTH+1:2];
   assign w_err    = (r_addr[1:0] != 2'b00) ||
                     ({2'b00, r_addr[31:2]} >= DEPTH);
   assign w_we     = w_fire && r_wr && !w_err;

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

   // Next-state selection for the IDLE/WAIT/RESP sequence
   always_comb begin
      w_state_nx = r_state;
      unique case (1'b1)
         (r_state == S_IDLE): if (w_accept) w_state_nx = S_WAIT;
         (r_state == S_WAIT): if (w_fire)   w_state_nx = S_RESP;
         (r_state == S_RESP): if (w_done)   w_state_nx = S_IDLE;
         default:                           w_state_nx = S_IDLE;
      endcase
   end

   // Control state, request capture and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_wr        <= 1'b0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_be        <= 4'd0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         // ready follows the state we are about to be in, so it rises
         // one cycle after the response handshake and after reset
         r_req_ready <= (w_state_nx == S_IDLE);
         if (w_accept) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_cnt   <= 4'(LATENCY);
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || r_wr) ? 32'd0 : r_mem[w_idx];
         end else if (w_done) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   // Byte-lane store into the uninitialised word array
   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int i = 0; i < 4; i++) begin
            if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard bench over three latency
// variants (2, 1, 15) sharing clock and reset.
module tb_data_memory_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_wr    [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_be    [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_err   [3];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   exp_t sbq [3][$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;

      data_memory_responder #(
         .ADDR_WIDTH(10),
         .LATENCY   (L)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .req_valid(req_valid[g]),
         .req_ready(req_ready[g]),
         .req_wr   (req_wr[g]),
         .req_addr (req_addr[g]),
         .req_wdata(req_wdata[g]),
         .req_be   (req_be[g]),
         .rsp_valid(rsp_valid[g]),
         .rsp_ready(rsp_ready[g]),
         .rsp_rdata(rsp_rdata[g]),
         .rsp_err  (rsp_err[g])
      );

      initial begin : mon
         bit          open;
         bit          hs;
         logic [31:0] hd;
         logic        he;
         exp_t        e;
         open = 0;
         hs   = 0;
         hd   = '0;
         he   = 1'b0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               open = 0;
               hs   = 0;
            end else begin
               if (hs) begin
                  chk($sformatf("d%0d ready_after_hs", g),
                      32'(req_ready[g]), 32'd1);
                  chk($sformatf("d%0d valid_after_hs", g),
                      32'(rsp_valid[g]), 32'd0);
               end
               hs = 0;
               if (rsp_valid[g]) begin
                  if (!open) begin
                     checks++;
                     if (sbq[g].size() == 0) begin
                        errors++;
                        $display("FAIL d%0d unexpected_rsp: got %h",
                                 g, rsp_rdata[g]);
                     end else begin
                        e = sbq[g].pop_front();
                        chk($sformatf("d%0d rdata", g),
                            rsp_rdata[g], e.rdata);
                        chk($sformatf("d%0d err", g),
                            32'(rsp_err[g]), 32'(e.err));
                        chk($sformatf("d%0d latency", g),
                            32'(cyc - e.acc), 32'(L));
                     end
                  end else begin
                     chk($sformatf("d%0d hold_rdata", g),
                         rsp_rdata[g], hd);
                     chk($sformatf("d%0d hold_err", g),
                         32'(rsp_err[g]), 32'(he));
                  end
                  chk($sformatf("d%0d ready_in_resp", g),
                      32'(req_ready[g]), 32'd0);
                  hd   = rsp_rdata[g];
                  he   = rsp_err[g];
                  open = !rsp_ready[g];
                  hs   = rsp_ready[g];
               end else begin
                  open = 0;
               end
            end
         end
      end
   end

   task automatic issue(input int d, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] er,
                        input bit ee, input bit want, output int acc);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_wr[d]    = wr;
      req_addr[d]  = a;
      req_wdata[d] = wd;
      req_be[d]    = be;
      while (!req_ready[d] && n < 300) begin
         @(negedge clk);
         n++;
      end
      acc = cyc + 1;
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL d%0d accept_timeout: waited %0d need <300", d, n);
      end else if (want) begin
         e.rdata = er;
         e.err   = ee;
         e.acc   = acc;
         sbq[d].push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      req_wr[d]    = ~wr;
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      req_be[d]    = 4'hF;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sbq[0].size() + sbq[1].size() + sbq[2].size() != 0 ||
              rsp_valid[0] || rsp_valid[1] || rsp_valid[2]) && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 400) begin
         errors++;
         $display("FAIL drain_timeout: waited %0d need <400", n);
      end
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: time %0t exceeded", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int prev;
      int lat;
      for (int i = 0; i < 3; i++) begin
         req_valid[i] = 1'b0;
         req_wr[i]    = 1'b0;
         req_addr[i]  = '0;
         req_wdata[i] = '0;
         req_be[i]    = '0;
         rsp_ready[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("d%0d rst_ready", i), 32'(req_ready[i]), 32'd0);
         chk($sformatf("d%0d rst_valid", i), 32'(rsp_valid[i]), 32'd0);
         chk($sformatf("d%0d rst_rdata", i), rsp_rdata[i], 32'd0);
         chk($sformatf("d%0d rst_err", i), 32'(rsp_err[i]), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         chk($sformatf("d%0d ready_post_rst", i), 32'(req_ready[i]), 32'd1);

      issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 1, acc);
      issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1, acc);
      issue(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 1, acc);
      issue(0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 0, 1, acc);
      issue(0, 0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 0, 1, acc);
      issue(0, 0, 32'h13, 32'h0, 4'hF, 32'h0, 1, 1, acc);
      issue(0, 0, 32'h1000, 32'h0, 4'hF, 32'h0, 1, 1, acc);
      issue(0, 1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 0, 1, acc);
      issue(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 1, acc);
      issue(0, 0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 0, 1, acc);
      issue(0, 1, 32'h22, 32'h99999999, 4'hF, 32'h0, 1, 1, acc);
      issue(0, 0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 0, 1, acc);
      issue(0, 1, 32'h10, 32'h12345678, 4'h0, 32'h0, 0, 1, acc);
      issue(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, 1, acc);
      issue(0, 1, 32'hFFC, 32'h0BADF00D, 4'hF, 32'h0, 0, 1, acc);
      issue(0, 0, 32'hFFC, 32'h0, 4'hF, 32'h0BADF00D, 0, 1, acc);
      drain();

      @(posedge clk);
      #1 rsp_ready[0] = 1'b0;
      issue(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, 1, acc);
      repeat (7) @(posedge clk);
      #1 rsp_ready[0] = 1'b1;
      drain();

      issue(0, 1, 32'h40, 32'h0, 4'hF, 32'h0, 0, 1, acc);
      drain();
      issue(0, 1, 32'h40, 32'h5555AAAA, 4'hF, 32'h0, 0, 0, acc);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("abort_valid0", 32'(rsp_valid[0]), 32'd0);
      chk("abort_ready0", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
      chk("abort_valid1", 32'(rsp_valid[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready_post", 32'(req_ready[0]), 32'd1);
      issue(0, 0, 32'h40, 32'h0, 4'hF, 32'h0, 0, 1, acc);
      drain();

      for (int d = 1; d < 3; d++) begin
         lat = (d == 1) ? 1 : 15;
         issue(d, 1, 32'h80, 32'h600D0000 + d, 4'hF, 32'h0, 0, 1, prev);
         for (int k = 0; k < 3; k++) begin
            issue(d, 0, 32'h80, 32'h0, 4'hF, 32'h600D0000 + d, 0, 1, acc);
            chk($sformatf("d%0d spacing%0d", d, k),
                32'(acc - prev), 32'(lat + 2));
            prev = acc;
         end
         drain();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, errors);
      $finish;
   end

endmodule
